// File: rtl/cheri_pkg.sv
// Shared CHERI temporal-safety-map definitions.
// Holds the TSMAP writer state encoding, geometry constants and the
// per-word range mask helper used by the mask generator.
package cheri_pkg;

  typedef enum logic [2:0] {
    TSW_IDLE,
    TSW_RD,
    TSW_MRG,
    TSW_WR,
    TSW_DONE
  } tsmap_wr_state_t;

  localparam int          TSMAP_GRAN_LOG2 = 3;    // 8-byte granules
  localparam int          TSMAP_WORD_BITS = 32;
  localparam int          TSMAP_BIT_IDX_W = 5;    // log2(TSMAP_WORD_BITS)
  localparam int          TSMAP_WIDX_W    = 11;   // word index field width
  localparam int          TSMAP_ADDR_W    = 16;
  localparam logic [31:0] TSMAP_HEAP_BASE = 32'h2001_0000;
  localparam int          TSMAP_SIZE      = 1024;

  // Bits of word w covered by granule range [lo_w:lo_b .. hi_w:hi_b].
  // Interior words get all ones; the end words are trimmed.
  function automatic logic [TSMAP_WORD_BITS-1:0] tsmap_mask(
    input logic [TSMAP_WIDX_W-1:0]    w,
    input logic [TSMAP_WIDX_W-1:0]    lo_w,
    input logic [TSMAP_BIT_IDX_W-1:0] lo_b,
    input logic [TSMAP_WIDX_W-1:0]    hi_w,
    input logic [TSMAP_BIT_IDX_W-1:0] hi_b
  );
    logic [TSMAP_BIT_IDX_W-1:0] sh_lo;
    logic [TSMAP_BIT_IDX_W-1:0] sh_hi;
    sh_lo = (w == lo_w) ? lo_b : '0;
    sh_hi = (w == hi_w) ? (5'd31 - hi_b) : '0;
    return ({TSMAP_WORD_BITS{1'b1}} << sh_lo) & ({TSMAP_WORD_BITS{1'b1}} >> sh_hi);
  endfunction

endpackage

// File: rtl/cheri_tsmap_mask_gen.sv
// Combinational TSMAP mask/merge generator.
// Ports:
//   cur_w_i        word index being updated
//   lo_w_i/lo_b_i  first covered granule (word, bit)
//   hi_w_i/hi_b_i  last covered granule (word, bit)
//   set_i          1 = set covered bits, 0 = clear them
//   old_i          current word contents
//   mask_o         covered bits of cur_w_i
//   merged_o       old_i with the covered bits set or cleared
module cheri_tsmap_mask_gen
  import cheri_pkg::*;
(
  input  logic [TSMAP_WIDX_W-1:0]    cur_w_i,
  input  logic [TSMAP_WIDX_W-1:0]    lo_w_i,
  input  logic [TSMAP_BIT_IDX_W-1:0] lo_b_i,
  input  logic [TSMAP_WIDX_W-1:0]    hi_w_i,
  input  logic [TSMAP_BIT_IDX_W-1:0] hi_b_i,
  input  logic                       set_i,
  input  logic [TSMAP_WORD_BITS-1:0] old_i,
  output logic [TSMAP_WORD_BITS-1:0] mask_o,
  output logic [TSMAP_WORD_BITS-1:0] merged_o
);

  assign mask_o   = tsmap_mask(cur_w_i, lo_w_i, lo_b_i, hi_w_i, hi_b_i);
  assign merged_o = set_i ? (old_i | mask_o) : (old_i & ~mask_o);

endmodule

// File: rtl/cheri_tsmap_wr.sv
// TSMAP writer: sets or clears the revocation bits of a heap byte range,
// one 32-bit TSMAP word at a time. Owns the TSMAP port and shares it with
// the load-revocation read path, which always has priority.
//
// Build option CHERI_TSMAP_BITWE_EN: the SRAM honours per-bit write
// enables, so each word is a single masked write (no read-modify-write).
//
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   cmd_valid_i/cmd_ready_o    command handshake
//   cmd_set_i                  1 = revoke (set), 0 = clear
//   cmd_base_i/cmd_top_i       byte range [base, top)
//   busy_o                     command in flight
//   done_o/err_o               completion pulse, err on rejected command
//   rd_req_i/rd_addr_i         priority revocation read
//   tsmap_*                    TSMAP SRAM port
module cheri_tsmap_wr
  import cheri_pkg::*;
#(
  parameter logic [31:0] HeapBase  = TSMAP_HEAP_BASE,
  parameter int          TSMapSize = TSMAP_SIZE
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_set_i,
  input  logic [31:0] cmd_base_i,
  input  logic [31:0] cmd_top_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  input  logic        rd_req_i,
  input  logic [15:0] rd_addr_i,
  output logic        tsmap_cs_o,
  output logic        tsmap_we_o,
  output logic [15:0] tsmap_addr_o,
  output logic [31:0] tsmap_wdata_o,
  output logic [31:0] tsmap_wbe_o,
  input  logic [31:0] tsmap_rdata_i
);

`ifdef CHERI_TSMAP_BITWE_EN
  localparam tsmap_wr_state_t WORD_START = TSW_WR;
`else
  localparam tsmap_wr_state_t WORD_START = TSW_RD;
`endif

  tsmap_wr_state_t             state_q;
  logic                        set_q, rej_q;
  logic [TSMAP_WIDX_W-1:0]     lo_w_q, hi_w_q, cur_w_q;
  logic [TSMAP_BIT_IDX_W-1:0]  lo_b_q, hi_b_q;

  // Granule indices in 33 bits so underflow and oversized ranges stay visible.
  logic [32:0] base_off, top_off, lo_idx, hi_idx;
  logic        cmd_rej;

  assign base_off = {1'b0, cmd_base_i} - {1'b0, HeapBase};
  assign top_off  = {1'b0, cmd_top_i} - {1'b0, HeapBase} + 33'd7;  // round up partial granule
  assign lo_idx   = base_off >> TSMAP_GRAN_LOG2;
  assign hi_idx   = (top_off >> TSMAP_GRAN_LOG2) - 33'd1;

  // Full-width word index check so huge tops cannot alias into the map.
  assign cmd_rej = (cmd_base_i < HeapBase) ||
                   (cmd_top_i <= cmd_base_i) ||
                   (hi_idx[32:TSMAP_BIT_IDX_W] >= 28'(TSMapSize));

  logic unused_idx;
  assign unused_idx = ^{lo_idx[32:16], base_off[2:0], top_off[2:0]};

  // Mask / merge
  logic [31:0] old_word, mask, merged, wbe_w;

`ifdef CHERI_TSMAP_BITWE_EN
  // Merging into zero yields set ? mask : 0, the write data for a masked write.
  assign old_word = '0;
  assign wbe_w    = mask;
  logic unused_rdata;
  assign unused_rdata = ^tsmap_rdata_i;
`else
  logic [31:0] word_q;
  assign old_word = word_q;
  assign wbe_w    = '1;
  logic unused_mask;
  assign unused_mask = ^mask;
`endif

  cheri_tsmap_mask_gen u_mask (
    .cur_w_i (cur_w_q),
    .lo_w_i  (lo_w_q),
    .lo_b_i  (lo_b_q),
    .hi_w_i  (hi_w_q),
    .hi_b_i  (hi_b_q),
    .set_i   (set_q),
    .old_i   (old_word),
    .mask_o  (mask),
    .merged_o(merged)
  );

  // FSM. The FSM's port requests are granted only when rd_req_i is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TSW_IDLE;
      set_q   <= 1'b0;
      rej_q   <= 1'b0;
      lo_w_q  <= '0;
      lo_b_q  <= '0;
      hi_w_q  <= '0;
      hi_b_q  <= '0;
      cur_w_q <= '0;
`ifndef CHERI_TSMAP_BITWE_EN
      word_q  <= '0;
`endif
    end else begin
      case (state_q)
        TSW_IDLE: if (cmd_valid_i) begin
          set_q   <= cmd_set_i;
          rej_q   <= cmd_rej;
          lo_w_q  <= lo_idx[15:5];
          lo_b_q  <= lo_idx[4:0];
          hi_w_q  <= hi_idx[15:5];
          hi_b_q  <= hi_idx[4:0];
          cur_w_q <= lo_idx[15:5];
          state_q <= cmd_rej ? TSW_DONE : WORD_START;
        end
`ifndef CHERI_TSMAP_BITWE_EN
        TSW_RD: if (!rd_req_i) state_q <= TSW_MRG;
        TSW_MRG: begin
          word_q  <= tsmap_rdata_i;
          state_q <= TSW_WR;
        end
`endif
        TSW_WR: if (!rd_req_i) begin
          if (cur_w_q == hi_w_q) begin
            state_q <= TSW_DONE;
          end else begin
            cur_w_q <= cur_w_q + 11'd1;
            state_q <= WORD_START;
          end
        end
        TSW_DONE: state_q <= TSW_IDLE;
        default:  state_q <= TSW_IDLE;
      endcase
    end
  end

  assign cmd_ready_o = (state_q == TSW_IDLE);
  assign busy_o      = (state_q != TSW_IDLE);
  assign done_o      = (state_q == TSW_DONE);
  assign err_o       = (state_q == TSW_DONE) && rej_q;

  // Port mux: revocation read first, then the FSM's read or write.
  always_comb begin
    tsmap_cs_o    = 1'b0;
    tsmap_we_o    = 1'b0;
    tsmap_addr_o  = '0;
    tsmap_wdata_o = '0;
    tsmap_wbe_o   = '0;
    if (rd_req_i) begin
      tsmap_cs_o   = 1'b1;
      tsmap_addr_o = rd_addr_i;
    end else if (state_q == TSW_RD) begin
      tsmap_cs_o   = 1'b1;
      tsmap_addr_o = {{(TSMAP_ADDR_W-TSMAP_WIDX_W){1'b0}}, cur_w_q};
    end else if (state_q == TSW_WR) begin
      tsmap_cs_o    = 1'b1;
      tsmap_we_o    = 1'b1;
      tsmap_addr_o  = {{(TSMAP_ADDR_W-TSMAP_WIDX_W){1'b0}}, cur_w_q};
      tsmap_wdata_o = merged;
      tsmap_wbe_o   = wbe_w;
    end
  end

endmodule

// File: tb/tb_cheri_tsmap_wr.sv
module tb_cheri_tsmap_wr;

  localparam logic [31:0] HB = 32'h2001_0000;
  localparam int          SZ = 1024;
`ifdef CHERI_TSMAP_BITWE_EN
  localparam int CPW = 1, APW = 1, RST_CYC = 1;
  localparam logic [31:0] CONT = 32'h0000_007E;  // WR blocked cycles 1..6
`else
  localparam int CPW = 3, APW = 2, RST_CYC = 3;
  localparam logic [31:0] CONT = 32'h0000_01CE;  // RD blocked 1..3, WR blocked 6..8
`endif

  logic        clk = 1'b0, rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_set_i = 1'b0;
  logic [31:0] cmd_base_i = '0, cmd_top_i = '0;
  logic        busy_o, done_o, err_o;
  logic        rd_req_i = 1'b0;
  logic [15:0] rd_addr_i = 16'h03AB;
  logic        tsmap_cs_o, tsmap_we_o;
  logic [15:0] tsmap_addr_o;
  logic [31:0] tsmap_wdata_o, tsmap_wbe_o, tsmap_rdata_i;

  cheri_tsmap_wr dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_set_i(cmd_set_i),
    .cmd_base_i(cmd_base_i), .cmd_top_i(cmd_top_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i),
    .tsmap_cs_o(tsmap_cs_o), .tsmap_we_o(tsmap_we_o), .tsmap_addr_o(tsmap_addr_o),
    .tsmap_wdata_o(tsmap_wdata_o), .tsmap_wbe_o(tsmap_wbe_o), .tsmap_rdata_i(tsmap_rdata_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SRAM model with a preload side port for the bench.
  logic [31:0] mem [SZ] = '{default: '0};
  logic [31:0] em  [SZ] = '{default: '0};
  logic        pre_en = 1'b0;
  int          pre_a = 0;
  logic [31:0] pre_d = '0;
  logic [31:0] rdata_q = '0;
  assign tsmap_rdata_i = rdata_q;

  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (tsmap_cs_o && int'(tsmap_addr_o) < SZ) begin
      if (tsmap_we_o)
        mem[tsmap_addr_o] <= (mem[tsmap_addr_o] & ~tsmap_wbe_o) | (tsmap_wdata_o & tsmap_wbe_o);
      else
        rdata_q <= mem[tsmap_addr_o];
    end
  end

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  // Scoreboard
  typedef struct {logic err; int lat; int acc;} exp_t;
  exp_t sb[$];
  int acc_cnt = 0, n_acc = 0, done_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_ni) begin
      if (cmd_valid_i && cmd_ready_o) begin
        acc_cnt = cnt;
        n_acc   = 0;
      end else if (tsmap_cs_o && !rd_req_i) n_acc++;
      if (done_o) begin
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("err", err_o, e.err);
          chk("latency", cnt - acc_cnt, e.lat);
          chk("accesses", n_acc, e.acc);
        end
        done_cnt++;
      end
    end
  end

  task automatic preload(input int a, input logic [31:0] d);
    @(posedge clk); #1;
    pre_en = 1'b1; pre_a = a; pre_d = d; em[a] = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic run_cmd(input logic s, input logic [31:0] b, input logic [31:0] t,
                         input logic [31:0] cont, input int extra);
    longint bo, to, lo, hi;
    logic   err;
    int     d0, k, n;
    exp_t   e;
    bo  = longint'({32'b0, b}) - longint'({32'b0, HB});
    to  = longint'({32'b0, t}) - longint'({32'b0, HB});
    err = (b < HB) || (t <= b);
    lo = 0; hi = 0;
    if (!err) begin
      lo = bo / 8;
      hi = (to + 7) / 8 - 1;
      if (hi / 32 >= SZ) err = 1'b1;
    end
    n = err ? 0 : int'(hi / 32 - lo / 32 + 1);
    e.err = err;
    e.lat = err ? 1 : CPW * n + 1 + extra;
    e.acc = APW * n;
    sb.push_back(e);
    if (!err) for (longint g = lo; g <= hi; g++) em[g / 32][g % 32] = s;

    @(posedge clk); #1;
    cmd_valid_i = 1'b1; cmd_set_i = s; cmd_base_i = b; cmd_top_i = t;
    d0 = done_cnt;
    @(negedge clk);
    chk("ready", cmd_ready_o, 1);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    k = 1;
    while (done_cnt == d0 && k < 300) begin
      rd_req_i = (k < 32) ? cont[k] : 1'b0;
      @(negedge clk);
      if (rd_req_i) chk("rd_path", {tsmap_cs_o, tsmap_we_o, tsmap_addr_o}, {2'b10, rd_addr_i});
      @(posedge clk); #1;
      k++;
    end
    rd_req_i = 1'b0;
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    if (!err)
      for (longint w = lo / 32 - 1; w <= hi / 32 + 1; w++)
        if (w >= 0 && w < SZ) chk($sformatf("mem[%0d]", w), mem[w], em[w]);
  endtask

  initial begin
    logic [31:0] b;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done_err", {done_o, err_o}, 0);
    chk("rst_port", {tsmap_cs_o, tsmap_we_o, tsmap_addr_o}, 0);
    chk("rst_wdata", tsmap_wdata_o, 0);
    chk("rst_wbe", tsmap_wbe_o, 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // Full word set, clear across a word boundary, unaligned set
    run_cmd(1'b1, HB, HB + 32'h100, 0, 0);
    preload(0, 32'hFFFF_FFFF);
    preload(1, 32'hFFFF_FFFF);
    run_cmd(1'b0, HB + 32'hF8, HB + 32'h110, 0, 0);
    chk("clr_w0", mem[0], 32'h7FFF_FFFF);
    chk("clr_w1", mem[1], 32'hFFFF_FFFC);
    preload(0, 32'h0);
    run_cmd(1'b1, HB + 32'h3, HB + 32'h9, 0, 0);
    chk("unaligned_w0", mem[0], 32'h0000_0003);

    // Rejected commands
    run_cmd(1'b1, HB - 32'h8, HB + 32'h8, 0, 0);
    run_cmd(1'b1, HB + 32'h40, HB + 32'h40, 0, 0);
    run_cmd(1'b1, HB, HB + SZ * 256 + 8, 0, 0);
    // Last legal granule
    run_cmd(1'b1, HB + SZ * 256 - 8, HB + SZ * 256, 0, 0);
    chk("last_word", mem[SZ-1], 32'h8000_0000);

    // Read-path contention
    preload(2, 32'h1234_0000);
    run_cmd(1'b1, HB + 32'h200, HB + 32'h204, CONT, 6);
    chk("contend_w2", mem[2], 32'h1234_0001);

    // Random ranges over preloaded words
    for (int i = 0; i < 20; i++) preload(i, $urandom);
    for (int i = 0; i < 4; i++) begin
      b = HB + $urandom_range(0, 16 * 256);
      run_cmd(1'($urandom_range(0, 1)), b, b + $urandom_range(1, 3 * 256), 0, 0);
    end

    // Reset during the first write of a 4-word command
    @(posedge clk); #1;
    cmd_valid_i = 1'b1; cmd_set_i = 1'b1; cmd_base_i = HB + 32'h400; cmd_top_i = HB + 32'h800;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    repeat (RST_CYC - 1) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("pre_rst_wr", {tsmap_cs_o, tsmap_we_o}, 2'b11);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_ready_busy", {cmd_ready_o, busy_o}, 2'b10);
    chk("mid_rst_done_err", {done_o, err_o}, 0);
    chk("mid_rst_port", {tsmap_cs_o, tsmap_we_o, tsmap_addr_o}, 0);
    chk("mid_rst_data", {tsmap_wdata_o, tsmap_wbe_o}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    repeat (3) @(posedge clk);
    chk("rst_no_write", mem[4], em[4]);
    run_cmd(1'b0, HB + 32'h10, HB + 32'h30, 0, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
